ecdsa_sign_ctrl: RTL and testbench
==================================

ECDSA_SIGN_CTRL -- requirements
Module: ecdsa_sign_ctrl

Interface
REQ-001 SHALL have parameter ARM_MAX, default 16: cycles allowed for eng_busy to rise after eng_start.
REQ-002 SHALL have parameter RUN_MAX, default 2**20: cycles allowed for eng_busy to fall once risen.
REQ-003 clk  in  1  single clock; all logic on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 ina_tdata  in  256  message beat.
REQ-006 ina_tvalid  in  1  input beat valid.
REQ-007 ina_tready  out  1  input beat accepted when high with ina_tvalid.
REQ-008 key_in  in  256  signing key; sampled at start.
REQ-009 eng_message  out  512  message held to engine.
REQ-010 eng_key  out  256  key held to engine.
REQ-011 eng_start  out  1  one-cycle start pulse to engine.
REQ-012 eng_busy  in  1  engine busy.
REQ-013 eng_sign  in  256  engine signature; valid when busy falls.
REQ-014 outa_tdata  out  256  signature beat.
REQ-015 outa_tvalid  out  1  signature valid.
REQ-016 outa_tready  in  1  downstream ready.
REQ-017 err_timeout  out  1  one-cycle pulse on any watchdog expiry.
REQ-018 job_count  out  16  count of signatures delivered.

Function
REQ-019 SHALL use states IDLE, LOAD_HI, START, ARM, RUN, OUT.
REQ-020 ina_tready SHALL be 1 only in IDLE and LOAD_HI.
- IDLE: beat handshake -> eng_message[255:0] <= ina_tdata, go LOAD_HI.
- LOAD_HI: beat handshake -> eng_message[511:256] <= ina_tdata, go START.
REQ-021 START SHALL last one cycle, with eng_start=1, eng_key <= key_in; go ARM.
REQ-022 eng_start SHALL be 0 in every state other than START.
REQ-023 ARM SHALL wait for eng_busy=1, then go RUN.
- Timeout: counter reaches ARM_MAX -> err_timeout=1, go IDLE.
REQ-024 RUN SHALL wait for eng_busy=0.
- On that cycle: outa_tdata <= eng_sign, go OUT.
- Timeout: counter reaches RUN_MAX -> err_timeout=1, go IDLE, no output beat.
REQ-025 Watchdog counter SHALL clear on entry to ARM and again on entry to RUN.
REQ-026 eng_busy during START, IDLE or LOAD_HI SHALL be ignored.
REQ-027 OUT: outa_tvalid=1 and outa_tdata stable until outa_tready=1.
- On handshake: job_count += 1 (wraps 0xFFFF -> 0x0000), go IDLE.
- outa_tvalid SHALL NOT depend combinationally on outa_tready.
REQ-028 Minimum latency SHALL be: last input beat at cycle N -> eng_start at N+1.
REQ-029 Minimum latency SHALL be: eng_busy falling seen at cycle M -> outa_tvalid at M+1.
REQ-030 Throughput SHALL be one job in flight; no input beat is accepted from START until OUT completes.
REQ-031 eng_message, eng_key and outa_tdata SHALL NOT change outside the load/capture points above.

Reset
REQ-032 rst=1 SHALL, on the next clock edge, force state IDLE and set to 0: eng_start, outa_tvalid, err_timeout, job_count, watchdog, eng_message, eng_key, outa_tdata.
REQ-033 ina_tready SHALL be 1 in the first cycle after rst deasserts.
REQ-034 rst asserted mid-job (any state) SHALL abort the job: no output beat, no err_timeout pulse.
REQ-035 rst SHALL take priority over every simultaneous handshake.

Verification
REQ-036 Normal job:
- Stimulus: beats A=0x11..11, B=0x22..22; engine raises busy 2 cycles after start, drops it 10 cycles later with sign=0xABCD.
- Response: eng_message={B,A}; one eng_start pulse; outa_tdata=0xABCD; job_count=1.
REQ-037 Output backpressure:
- Stimulus: outa_tready held 0 for 5 cycles in OUT, then 1.
- Response: outa_tvalid=1 with stable data throughout; ina_tready=0; exactly one beat delivered.
REQ-038 Arm timeout:
- Stimulus: ARM_MAX=4, eng_busy never rises.
- Response: err_timeout pulse, IDLE, no outa_tvalid, job_count unchanged.
REQ-039 Run timeout:
- Stimulus: RUN_MAX=8, busy stuck 1.
- Response: err_timeout after 8 RUN cycles; next job then completes normally.
REQ-040 Reset mid-run:
- Stimulus: rst in RUN.
- Response: next cycle all outputs 0, ina_tready=1, no err_timeout.
REQ-041 Wrap:
- Stimulus: preload job_count=0xFFFF, complete one job.
- Response: job_count=0x0000.

Source files
------------

// File: rtl/ecdsa_sign_ctrl_if.sv
// rtl/ecdsa_sign_ctrl_if.sv - message/signature streams and signing-engine bundle for ecdsa_sign_ctrl
interface ecdsa_sign_ctrl_if;
  logic [255:0] ina_tdata;
  logic         ina_tvalid;
  logic         ina_tready;
  logic [511:0] eng_message;
  logic [255:0] eng_key;
  logic         eng_start;
  logic         eng_busy;
  logic [255:0] eng_sign;
  logic [255:0] outa_tdata;
  logic         outa_tvalid;
  logic         outa_tready;

  modport slave (
    input  ina_tdata, ina_tvalid,
    output ina_tready,
    output eng_message, eng_key, eng_start,
    input  eng_busy, eng_sign,
    output outa_tdata, outa_tvalid,
    input  outa_tready
  );

  modport master (
    output ina_tdata, ina_tvalid,
    input  ina_tready,
    input  eng_message, eng_key, eng_start,
    output eng_busy, eng_sign,
    input  outa_tdata, outa_tvalid,
    output outa_tready
  );
endinterface

// File: rtl/ecdsa_sign_ctrl.sv
// rtl/ecdsa_sign_ctrl.sv - single-job ECDSA signing sequencer with arm/run watchdogs
module ecdsa_sign_ctrl #(
  parameter int ARM_MAX = 16,
  parameter int RUN_MAX = 2**20
) (
  input  logic               clk,
  input  logic               rst,
  ecdsa_sign_ctrl_if.slave   bus,
  input  logic [255:0]       key_in,
  output logic               err_timeout,
  output logic [15:0]        job_count
);

  localparam int WD_MAX = (RUN_MAX > ARM_MAX) ? RUN_MAX : ARM_MAX;
  localparam int WD_W   = $clog2(WD_MAX) + 1;
  localparam logic [WD_W-1:0] ARM_LAST = WD_W'(ARM_MAX - 1);
  localparam logic [WD_W-1:0] RUN_LAST = WD_W'(RUN_MAX - 1);

  typedef enum logic [2:0] {IDLE, LOAD_HI, START, ARM, RUN, OUT} state_t;

  state_t          state, state_nxt;
  logic [WD_W-1:0] wd;
  logic [511:0]    msg_q;
  logic [255:0]    key_q;
  logic [255:0]    sign_q;

  logic load_lo, load_hi, load_key, cap_sign, wd_clr, wd_inc, timeout, deliver;
  logic in_ready, start_pulse, out_valid;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    load_lo     = 1'b0;
    load_hi     = 1'b0;
    load_key    = 1'b0;
    cap_sign    = 1'b0;
    wd_clr      = 1'b0;
    wd_inc      = 1'b0;
    timeout     = 1'b0;
    deliver     = 1'b0;
    in_ready    = 1'b0;
    start_pulse = 1'b0;
    out_valid   = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (bus.ina_tvalid) begin
          load_lo   = 1'b1;
          state_nxt = LOAD_HI;
        end
      end
      LOAD_HI: begin
        in_ready = 1'b1;
        if (bus.ina_tvalid) begin
          load_hi   = 1'b1;
          state_nxt = START;
        end
      end
      START: begin
        start_pulse = 1'b1;
        load_key    = 1'b1;
        wd_clr      = 1'b1;
        state_nxt   = ARM;
      end
      ARM: begin
        // busy wins over an expiring watchdog on the same cycle
        if (bus.eng_busy) begin
          wd_clr    = 1'b1;
          state_nxt = RUN;
        end else if (wd == ARM_LAST) begin
          timeout   = 1'b1;
          state_nxt = IDLE;
        end else begin
          wd_inc = 1'b1;
        end
      end
      RUN: begin
        if (!bus.eng_busy) begin
          cap_sign  = 1'b1;
          state_nxt = OUT;
        end else if (wd == RUN_LAST) begin
          timeout   = 1'b1;
          state_nxt = IDLE;
        end else begin
          wd_inc = 1'b1;
        end
      end
      OUT: begin
        out_valid = 1'b1;
        if (bus.outa_tready) begin
          deliver   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      msg_q       <= '0;
      key_q       <= '0;
      sign_q      <= '0;
      wd          <= '0;
      err_timeout <= 1'b0;
      job_count   <= '0;
    end else begin
      err_timeout <= timeout;
      if (load_lo)  msg_q[255:0]   <= bus.ina_tdata;
      if (load_hi)  msg_q[511:256] <= bus.ina_tdata;
      if (load_key) key_q          <= key_in;
      if (cap_sign) sign_q         <= bus.eng_sign;
      if (wd_clr)      wd <= '0;
      else if (wd_inc) wd <= wd + 1'b1;
      if (deliver)  job_count <= job_count + 16'd1;
    end
  end

  assign bus.ina_tready  = in_ready;
  assign bus.eng_start   = start_pulse;
  assign bus.eng_message = msg_q;
  assign bus.eng_key     = key_q;
  assign bus.outa_tdata  = sign_q;
  assign bus.outa_tvalid = out_valid;

endmodule

// File: tb/tb_ecdsa_sign_ctrl.sv
// tb/tb_ecdsa_sign_ctrl.sv - table, random and directed checks for ecdsa_sign_ctrl
module tb_ecdsa_sign_ctrl;

  typedef struct {
    logic [255:0] a, b, key, sign;
    int rise, hold, rdly, gap;
  } job_t;

  typedef struct {
    bit   sel;
    job_t j;
    bit   exp_to;
    int   exp_t;
  } vec_t;

  logic clk, rst;
  logic [255:0] key_in, ina_tdata, eng_sign;
  logic ina_tvalid, eng_busy, outa_tready;
  logic m_err, t_err;
  logic [15:0] m_cnt, t_cnt;
  bit sel;

  logic o_ina_tready, o_eng_start, o_outa_tvalid, o_err_timeout;
  logic [511:0] o_eng_message;
  logic [255:0] o_eng_key, o_outa_tdata;
  logic [15:0] o_job_count;

  int checks, errors;
  logic [15:0] model_count;

  ecdsa_sign_ctrl_if m_if ();
  ecdsa_sign_ctrl_if t_if ();

  assign m_if.ina_tdata = ina_tdata;  assign t_if.ina_tdata = ina_tdata;
  assign m_if.ina_tvalid = ina_tvalid; assign t_if.ina_tvalid = ina_tvalid;
  assign m_if.eng_busy = eng_busy;    assign t_if.eng_busy = eng_busy;
  assign m_if.eng_sign = eng_sign;    assign t_if.eng_sign = eng_sign;
  assign m_if.outa_tready = outa_tready; assign t_if.outa_tready = outa_tready;

  ecdsa_sign_ctrl dut_m (
    .clk(clk), .rst(rst), .bus(m_if.slave), .key_in(key_in),
    .err_timeout(m_err), .job_count(m_cnt)
  );

  ecdsa_sign_ctrl #(.ARM_MAX(4), .RUN_MAX(8)) dut_t (
    .clk(clk), .rst(rst), .bus(t_if.slave), .key_in(key_in),
    .err_timeout(t_err), .job_count(t_cnt)
  );

  always_comb begin
    o_ina_tready  = sel ? t_if.ina_tready  : m_if.ina_tready;
    o_eng_start   = sel ? t_if.eng_start   : m_if.eng_start;
    o_outa_tvalid = sel ? t_if.outa_tvalid : m_if.outa_tvalid;
    o_eng_message = sel ? t_if.eng_message : m_if.eng_message;
    o_eng_key     = sel ? t_if.eng_key     : m_if.eng_key;
    o_outa_tdata  = sel ? t_if.outa_tdata  : m_if.outa_tdata;
    o_err_timeout = sel ? t_err : m_err;
    o_job_count   = sel ? t_cnt : m_cnt;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_time_limit act=expired exp=finished");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] rand256();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  // Outcome from the engine timeline: ARM sees busy at t=rise, RUN then sees hold-1 busy cycles.
  task automatic predict(input job_t j, input int arm_max, input int run_max,
                         output bit to, output int t);
    if (j.rise - 1 >= arm_max) begin
      to = 1'b1; t = arm_max + 1;
    end else if (j.hold - 1 >= run_max) begin
      to = 1'b1; t = j.rise + run_max + 1;
    end else begin
      to = 1'b0; t = j.rise + j.hold + 1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; ina_tvalid = 1'b0; eng_busy = 1'b0; outa_tready = 1'b0;
    step();
    rst = 1'b0;
    model_count = 16'h0000;
  endtask

  task automatic use_dut(input bit s);
    if (s != sel) begin
      sel = s;
      do_reset();
    end
  endtask

  task automatic run_and_check(input job_t j, input bit exp_to, input int exp_t, input string tag);
    int starts, ev_t;
    bit saw_to, saw_v, rdy_seen, stable;
    logic [255:0] held;
    starts = 0; ev_t = -1; saw_to = 0; saw_v = 0; rdy_seen = 0; stable = 1;
    key_in = j.key; ina_tdata = j.a; ina_tvalid = 1'b1;
    check({tag, ".rdy_lo"}, o_ina_tready, 1'b1);
    step();
    ina_tvalid = 1'b0;
    repeat (j.gap) step();
    ina_tdata = j.b; ina_tvalid = 1'b1;
    check({tag, ".rdy_hi"}, o_ina_tready, 1'b1);
    step();
    ina_tvalid = 1'b0; ina_tdata = rand256();
    check({tag, ".start_lat"}, o_eng_start, 1'b1);
    check({tag, ".msg"}, o_eng_message, {j.b, j.a});
    for (int t = 0; t < 64; t++) begin
      if (o_err_timeout) begin saw_to = 1; ev_t = t; break; end
      if (o_outa_tvalid) begin saw_v = 1; ev_t = t; break; end
      if (o_eng_start) starts++;
      if (o_ina_tready) rdy_seen = 1;
      if (t == 1) begin
        check({tag, ".key"}, o_eng_key, j.key);
        key_in = ~j.key;
      end
      eng_busy = (t >= j.rise) && (t < j.rise + j.hold);
      eng_sign = (t == j.rise + j.hold) ? j.sign : rand256();
      step();
    end
    eng_busy = 1'b0; eng_sign = rand256();
    check({tag, ".timeout"}, saw_to, exp_to);
    check({tag, ".event_cycle"}, ev_t, exp_t);
    check({tag, ".start_pulses"}, starts, 1);
    check({tag, ".no_accept_busy"}, rdy_seen, 1'b0);
    if (saw_v) begin
      held = o_outa_tdata;
      check({tag, ".sign"}, held, j.sign);
      outa_tready = 1'b0;
      repeat (j.rdly) begin
        step();
        eng_sign = rand256();
        if (!o_outa_tvalid || o_outa_tdata !== held || o_ina_tready) stable = 0;
      end
      check({tag, ".hold_stable"}, stable, 1'b1);
      outa_tready = 1'b1;
      step();
      outa_tready = 1'b0;
      model_count = model_count + 16'd1;
      check({tag, ".one_beat"}, o_outa_tvalid, 1'b0);
      check({tag, ".rdy_after"}, o_ina_tready, 1'b1);
      check({tag, ".count"}, o_job_count, model_count);
    end else if (saw_to) begin
      step();
      check({tag, ".pulse_len"}, o_err_timeout, 1'b0);
      check({tag, ".no_beat"}, o_outa_tvalid, 1'b0);
      check({tag, ".count"}, o_job_count, model_count);
    end
  endtask

  function automatic vec_t mk(input bit s, input logic [255:0] a, input logic [255:0] b,
                              input logic [255:0] sign, input int rise, input int hold,
                              input int rdly, input bit to, input int t);
    vec_t v;
    v.sel = s; v.j.a = a; v.j.b = b; v.j.key = ~a ^ {b[127:0], b[255:128]}; v.j.sign = sign;
    v.j.rise = rise; v.j.hold = hold; v.j.rdly = rdly; v.j.gap = 0;
    v.exp_to = to; v.exp_t = t;
    return v;
  endfunction

  initial begin
    vec_t vecs[8];
    logic [255:0] pa, pb, junk;
    job_t rj;
    bit r_to;
    int r_t;
    bit bad;

    pa = {32{8'h11}};
    pb = {32{8'h22}};
    vecs[0] = mk(0, pa, pb, 256'hABCD, 2, 10, 0, 0, 13);
    vecs[1] = mk(0, pb, pa, 256'h5A5A_0001, 1, 3, 5, 0, 5);
    vecs[2] = mk(1, pa, pb, 256'h1, 9, 3, 0, 1, 5);
    vecs[3] = mk(1, pa, pb, 256'h2, 2, 40, 0, 1, 11);
    vecs[4] = mk(1, pb, pa, 256'h3, 1, 8, 2, 0, 10);
    vecs[5] = mk(1, pa, pa, 256'h4, 4, 1, 0, 0, 6);
    vecs[6] = mk(1, pb, pb, 256'h5, 5, 1, 0, 1, 5);
    vecs[7] = mk(1, pa, pb, 256'h6, 1, 9, 0, 1, 10);

    checks = 0; errors = 0; sel = 0; model_count = 0;
    rst = 1'b1; key_in = '0; ina_tdata = rand256(); ina_tvalid = 1'b1;
    eng_busy = 1'b1; eng_sign = '0; outa_tready = 1'b1;
    step();
    step();
    check("rst.message", o_eng_message, 512'h0);
    check("rst.key", o_eng_key, 256'h0);
    check("rst.tdata", o_outa_tdata, 256'h0);
    check("rst.tvalid", o_outa_tvalid, 1'b0);
    check("rst.start", o_eng_start, 1'b0);
    check("rst.err", o_err_timeout, 1'b0);
    check("rst.count", o_job_count, 16'h0);
    rst = 1'b0; ina_tvalid = 1'b0; eng_busy = 1'b0; outa_tready = 1'b0;
    check("rst.rdy_first", o_ina_tready, 1'b1);

    for (int i = 0; i < 8; i++) begin
      use_dut(vecs[i].sel);
      run_and_check(vecs[i].j, vecs[i].exp_to, vecs[i].exp_t, $sformatf("vec%0d", i));
    end

    use_dut(1);
    for (int i = 0; i < 40; i++) begin
      rj.a = rand256(); rj.b = rand256(); rj.key = rand256(); rj.sign = rand256();
      rj.rise = $urandom_range(1, 6); rj.hold = $urandom_range(1, 11);
      rj.rdly = $urandom_range(0, 3); rj.gap = $urandom_range(0, 2);
      predict(rj, 4, 8, r_to, r_t);
      run_and_check(rj, r_to, r_t, $sformatf("rnd%0d", i));
    end

    use_dut(0);
    force dut_m.job_count = 16'hFFFF;
    step();
    release dut_m.job_count;
    step();
    check("wrap.preload", o_job_count, 16'hFFFF);
    model_count = 16'hFFFF;
    rj = vecs[0].j;
    run_and_check(rj, 1'b0, 13, "wrap");
    check("wrap.count", o_job_count, 16'h0000);

    // abort a job in RUN with a reset pulse
    junk = rand256();
    key_in = junk; ina_tdata = pa; ina_tvalid = 1'b1;
    step();
    ina_tdata = pb;
    step();
    ina_tvalid = 1'b0; eng_busy = 1'b1; eng_sign = junk;
    repeat (4) step();
    rst = 1'b1;
    step();
    rst = 1'b0; eng_busy = 1'b0;
    check("midrst.rdy", o_ina_tready, 1'b1);
    check("midrst.message", o_eng_message, 512'h0);
    check("midrst.key", o_eng_key, 256'h0);
    check("midrst.tdata", o_outa_tdata, 256'h0);
    check("midrst.tvalid", o_outa_tvalid, 1'b0);
    check("midrst.count", o_job_count, 16'h0);
    bad = 0;
    for (int k = 0; k < 12; k++) begin
      if (o_err_timeout || o_outa_tvalid || o_eng_start) bad = 1;
      step();
    end
    check("midrst.quiet", bad, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
